mult_rx_fifo: RTL and testbench
===============================

# mult_rx_fifo

Receive-side buffer for the pipelined Karatsuba-Ofman multiplier's product stream. It accepts products with their sideband control word, stores them in a DEPTH-entry first-word-fall-through FIFO, and presents them downstream on a valid/ready interface. It drives the multiplier's global stall input from a registered occupancy check, so no in-flight product is lost or duplicated. It sits directly after the multiplier output, in front of the reduction and accumulate logic.

## Interface
- BITS, 256: multiplier operand width; product width is 2*BITS.
- CTL_BITS, 8: sideband control/tag width, carried unmodified.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_mul_val  in  1  multiplier product valid.
- i_mul_ctl  in  CTL_BITS  multiplier control word.
- i_mul_dat  in  2*BITS  multiplier product.
- o_mul_rdy  out  1  registered; drives the multiplier's i_rdy, which stalls its whole pipeline.
- o_val  out  1  head entry valid.
- o_ctl  out  CTL_BITS  head control word.
- o_dat  out  2*BITS  head product.
- i_rdy  in  1  downstream ready.
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- o_beats  out  32  accepted-beat counter; present only with the statistics macro.
- o_stalls  out  32  stall-cycle counter; present only with the statistics macro.

## Operation
- Push: a push occurs when i_mul_val && o_mul_rdy. The multiplier holds o_val and o_dat frozen while rdy is low, so a held beat must not be pushed twice.
- Pop: a pop occurs when o_val && i_rdy.
- Storage: circular buffer with a write pointer and a read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH. o_count tracks occupancy from 0 to DEPTH.
- Next-count rule: count_next = count + push - pop.
- Ready rule: o_mul_rdy <= (count_next < DEPTH). The registered rdy therefore guarantees one free slot for any push in the following cycle, so the FIFO never overflows.
- Output: o_val, o_ctl and o_dat are registered from the head entry (FWFT).
- Empty with push: the head loads the pushed entry directly; o_val goes to 1 on the next cycle.
- Pop and push in the same cycle, count > 1: the head advances to the next stored entry; the push writes at the tail.
- Pop and push in the same cycle, count == 1: the head loads the pushed entry; count stays 1.
- Full: o_mul_rdy is already 0, so no push can occur. A pop while full sets o_mul_rdy to 1 on the next cycle.
- Downstream stall: while o_val=1 and i_rdy=0, o_ctl and o_dat are held stable.
- Ordering: strict FIFO order, no reordering.
- Reset (including mid-operation): pointers, count, o_val, o_ctl, o_dat, o_mul_rdy and the counters all reset to 0. Stored contents are discarded.

## Timing
- Push to o_val: 1 cycle when the FIFO is empty.
- Pop to o_mul_rdy rise: 1 cycle.
- After i_rst deasserts, o_mul_rdy becomes 1 at the first clock edge.
- Sustained throughput: 1 beat per cycle when i_rdy is held at 1. o_mul_rdy never drops in that case, because count_next stays at most 1.
- Zero combinational paths from any input to o_mul_rdy, o_val, o_ctl or o_dat.

## Configuration
- MULT_RX_STATS_EN defined:
  - o_beats increments on every push.
  - o_stalls increments on every cycle with i_mul_val && !o_mul_rdy.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- MULT_RX_STATS_EN undefined: both ports and both counters are absent. All other behaviour is identical.

## Structure
- Shared package mult_pkg holds:
  - typedef mult_prod_t: logic [2*BITS-1:0] at the default BITS.
  - typedef mult_ctl_t.
  - localparam MULT_RX_DEPTH_DEFAULT.
- Sub-module mult_rx_ram: DEPTH x (2*BITS+CTL_BITS) storage with one write port and one asynchronous read port. The head register lives in mult_rx_fifo.

## Test plan
- Reset then single push (ctl=8'h11, dat=512'h5): o_val=1 one cycle later with ctl 8'h11, dat 5; o_count=1 until the pop.
- i_rdy=0 and 6 consecutive valid pushes at DEPTH=4:
  - exactly 4 entries accepted;
  - o_mul_rdy falls the cycle after the 4th push;
  - beats 5 and 6 are held upstream.
- Release i_rdy=1 after fill: outputs ctl 1,2,3,4,5,6 in order with no duplicates; o_mul_rdy returns to 1 one cycle after the first pop.
- Continuous push and pop with i_rdy=1 for 100 beats: o_mul_rdy stays 1, o_count stays at most 1, output ctl sequence matches input.
- Assert i_rst with 3 entries stored: next cycle o_val=0, o_count=0, o_mul_rdy=0; later pushes produce only post-reset data.
- With MULT_RX_STATS_EN, fill scenario (6 offered, 4 accepted, 2 beats held 3 cycles): o_beats=4 and o_stalls=3 before release.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the Karatsuba-Ofman multiplier datapath.
package mult_pkg;

   localparam int unsigned MULT_BITS_DEFAULT     = 256;
   localparam int unsigned MULT_CTL_BITS_DEFAULT = 8;
   localparam int unsigned MULT_RX_DEPTH_DEFAULT = 4;

   typedef logic [2*MULT_BITS_DEFAULT-1:0]   mult_prod_t;
   typedef logic [MULT_CTL_BITS_DEFAULT-1:0] mult_ctl_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/mult_rx_ram.sv
// Product/control storage for mult_rx_fifo: one write port, one asynchronous read port.
module mult_rx_ram #(
   parameter int unsigned WIDTH = 520,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdat,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdat
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) mem[i_waddr] <= i_wdat;
   end

   assign o_rdat = mem[i_raddr];

endmodule

// File: rtl/mult_rx_fifo.sv
// FWFT receive buffer for the multiplier product stream with registered upstream stall.
// Optional statistics counters (o_beats, o_stalls) are built when MULT_RX_STATS_EN is defined.
module mult_rx_fifo
   import mult_pkg::*;
#(
   parameter int unsigned BITS     = MULT_BITS_DEFAULT,
   parameter int unsigned CTL_BITS = MULT_CTL_BITS_DEFAULT,
   parameter int unsigned DEPTH    = MULT_RX_DEPTH_DEFAULT
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_mul_val,
   input  logic [CTL_BITS-1:0]        i_mul_ctl,
   input  logic [2*BITS-1:0]          i_mul_dat,
   output logic                       o_mul_rdy,
   output logic                       o_val,
   output logic [CTL_BITS-1:0]        o_ctl,
   output logic [2*BITS-1:0]          o_dat,
   input  logic                       i_rdy,
`ifdef MULT_RX_STATS_EN
   output logic [31:0]                o_beats,
   output logic [31:0]                o_stalls,
`endif
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned W  = 2*BITS + CTL_BITS;

   logic          push, pop;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_next;
   logic [W-1:0]  ram_rdat;
   logic [W-1:0]  head_src;
   logic          head_ld;

   assign push = i_mul_val & o_mul_rdy;
   assign pop  = o_val & i_rdy;

   // Every entry, including the one shown at the head, lives in the RAM at
   // rd_ptr; the async read of rd_ptr+1 supplies the successor on a pop.
   mult_rx_ram #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (push),
      .i_waddr (wr_ptr),
      .i_wdat  ({i_mul_ctl, i_mul_dat}),
      .i_raddr (rd_ptr + AW'(1)),
      .o_rdat  (ram_rdat)
   );

   always_comb begin
      count_next = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      head_ld    = 1'b0;
      head_src   = {i_mul_ctl, i_mul_dat};
      if (pop && (count > CW'(1))) begin
         head_ld  = 1'b1;
         head_src = ram_rdat;
      end else if (push && ((count == '0) || (pop && (count == CW'(1))))) begin
         head_ld  = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         o_val     <= 1'b0;
         o_ctl     <= '0;
         o_dat     <= '0;
         o_mul_rdy <= 1'b0;
      end else begin
         count     <= count_next;
         o_val     <= (count_next != '0);
         o_mul_rdy <= (count_next < CW'(DEPTH));
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (head_ld) {o_ctl, o_dat} <= head_src;
      end
   end

   assign o_count = count;

`ifdef MULT_RX_STATS_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_beats  <= '0;
         o_stalls <= '0;
      end else begin
         if (push) o_beats <= sat_inc32(o_beats);
         if (i_mul_val && !o_mul_rdy) o_stalls <= sat_inc32(o_stalls);
      end
   end
`endif

endmodule

// File: tb/tb_mult_rx_fifo.sv
// Directed self-checking bench for mult_rx_fifo at BITS=256, CTL_BITS=8, DEPTH=4.
module tb_mult_rx_fifo;

   localparam int unsigned BITS     = 256;
   localparam int unsigned CTL_BITS = 8;
   localparam int unsigned DEPTH    = 4;

   logic                  i_clk = 1'b0;
   logic                  i_rst = 1'b1;
   logic                  i_mul_val = 1'b0;
   logic [CTL_BITS-1:0]   i_mul_ctl = '0;
   logic [2*BITS-1:0]     i_mul_dat = '0;
   logic                  o_mul_rdy;
   logic                  o_val;
   logic [CTL_BITS-1:0]   o_ctl;
   logic [2*BITS-1:0]     o_dat;
   logic                  i_rdy = 1'b0;
   logic [$clog2(DEPTH):0] o_count;
`ifdef MULT_RX_STATS_EN
   logic [31:0]           o_beats;
   logic [31:0]           o_stalls;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 i_clk = ~i_clk;

   mult_rx_fifo #(
      .BITS     (BITS),
      .CTL_BITS (CTL_BITS),
      .DEPTH    (DEPTH)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_mul_val (i_mul_val),
      .i_mul_ctl (i_mul_ctl),
      .i_mul_dat (i_mul_dat),
      .o_mul_rdy (o_mul_rdy),
      .o_val     (o_val),
      .o_ctl     (o_ctl),
      .o_dat     (o_dat),
      .i_rdy     (i_rdy),
`ifdef MULT_RX_STATS_EN
      .o_beats   (o_beats),
      .o_stalls  (o_stalls),
`endif
      .o_count   (o_count)
   );

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      int unsigned k;
      int unsigned npop;
      int unsigned exp_ctl;
      int unsigned got_q [$];

      // Reset state
      tick();
      tick();
      check_eq("rst_val",   o_val, 0);
      check_eq("rst_count", o_count, 0);
      check_eq("rst_rdy",   o_mul_rdy, 0);
      check_eq("rst_dat",   o_dat, 0);
      i_rst = 1'b0;
      tick();
      check_eq("rdy_after_rst", o_mul_rdy, 1);

      // Single push, then held by downstream, then popped
      i_mul_val = 1'b1; i_mul_ctl = 8'h11; i_mul_dat = 512'h5;
      tick();
      i_mul_val = 1'b0;
      check_eq("single_val",   o_val, 1);
      check_eq("single_ctl",   o_ctl, 8'h11);
      check_eq("single_dat",   o_dat, 512'h5);
      check_eq("single_count", o_count, 1);
      tick();
      check_eq("single_hold_count", o_count, 1);
      check_eq("single_hold_ctl",   o_ctl, 8'h11);
      i_rdy = 1'b1;
      tick();
      check_eq("single_pop_val",   o_val, 0);
      check_eq("single_pop_count", o_count, 0);

      // Fill with downstream stalled: 6 offered, 4 accepted
      i_rdy = 1'b0;
      k = 1;
      for (int c = 0; c < 4; c++) begin
         i_mul_val = 1'b1; i_mul_ctl = k[7:0]; i_mul_dat = 512'(k * 32'h101);
         if (o_mul_rdy) k++;
         tick();
      end
      check_eq("fill_accepted", k, 5);
      check_eq("fill_rdy_low",  o_mul_rdy, 0);
      check_eq("fill_count",    o_count, 4);
      check_eq("fill_head_ctl", o_ctl, 8'h01);
      for (int c = 0; c < 3; c++) begin
         i_mul_val = 1'b1; i_mul_ctl = k[7:0]; i_mul_dat = 512'(k * 32'h101);
         if (o_mul_rdy) k++;
         tick();
      end
      check_eq("held_count",    o_count, 4);
      check_eq("held_head_ctl", o_ctl, 8'h01);
      check_eq("held_head_dat", o_dat, 512'h101);
      check_eq("held_not_taken", k, 5);
`ifdef MULT_RX_STATS_EN
      check_eq("stats_beats",  o_beats, 4);
      check_eq("stats_stalls", o_stalls, 3);
`endif

      // Release downstream; rdy must rise one cycle after the first pop
      i_rdy = 1'b1;
      got_q.push_back(int'(o_ctl));
      check_eq("first_pop_dat", o_dat, 512'h101);
      tick();
      check_eq("rdy_after_pop", o_mul_rdy, 1);
      check_eq("count_after_pop", o_count, 3);
      for (int c = 0; c < 20; c++) begin
         i_mul_val = (k <= 6);
         i_mul_ctl = k[7:0];
         i_mul_dat = 512'(k * 32'h101);
         if (o_val && i_rdy) begin
            got_q.push_back(int'(o_ctl));
            check_eq("drain_dat", o_dat, 512'(o_ctl * 32'h101));
         end
         if (i_mul_val && o_mul_rdy) k++;
         tick();
      end
      i_mul_val = 1'b0;
      check_eq("drain_n", got_q.size(), 6);
      for (int i = 0; i < got_q.size(); i++)
         check_eq("drain_order", got_q[i], i + 1);
      check_eq("drain_empty", o_count, 0);

      // Sustained 1 beat/cycle
      k = 0; npop = 0; exp_ctl = 0;
      for (int c = 0; c < 102; c++) begin
         i_mul_val = (k < 100);
         i_mul_ctl = k[7:0];
         i_mul_dat = 512'(k);
         if (c > 0) begin
            check_eq("stream_rdy", o_mul_rdy, 1);
            check_eq("stream_count_le1", (o_count <= 1), 1);
         end
         if (o_val && i_rdy) begin
            check_eq("stream_ctl", o_ctl, exp_ctl[7:0]);
            check_eq("stream_dat", o_dat, 512'(exp_ctl));
            exp_ctl++;
            npop++;
         end
         if (i_mul_val && o_mul_rdy) k++;
         tick();
      end
      i_mul_val = 1'b0;
      check_eq("stream_npop", npop, 100);
      tick();

      // Reset with 3 entries stored
      i_rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         i_mul_val = 1'b1; i_mul_ctl = 8'hA0 + c[7:0]; i_mul_dat = 512'hDEAD;
         tick();
      end
      i_mul_val = 1'b0;
      check_eq("pre_rst_count", o_count, 3);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check_eq("mid_rst_val",   o_val, 0);
      check_eq("mid_rst_count", o_count, 0);
      check_eq("mid_rst_rdy",   o_mul_rdy, 0);
`ifdef MULT_RX_STATS_EN
      check_eq("mid_rst_beats", o_beats, 0);
`endif
      tick();
      check_eq("post_rst_rdy", o_mul_rdy, 1);
      i_mul_val = 1'b1; i_mul_ctl = 8'hC3; i_mul_dat = 512'h7;
      tick();
      i_mul_val = 1'b0;
      check_eq("post_rst_val",   o_val, 1);
      check_eq("post_rst_ctl",   o_ctl, 8'hC3);
      check_eq("post_rst_dat",   o_dat, 512'h7);
      check_eq("post_rst_count", o_count, 1);
      i_rdy = 1'b1;
      tick();
      check_eq("post_rst_drained", o_val, 0);
      tick();
      check_eq("post_rst_no_stale", o_val, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
